// File: rtl/issue_pkg.sv
//------------------------------------------------------------------------------
// Module : issue_pkg
// Brief  : Shared issue-queue types (queue select, write request, dispatch FSM).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package issue_pkg;

  localparam int NUM_IQ = 3;
  localparam int ROB_W  = 6;
  localparam int UOP_W  = 16;

  typedef logic [1:0] iq_sel_t;

  localparam iq_sel_t IQ_ALU  = 2'd0;
  localparam iq_sel_t IQ_BR   = 2'd1;
  localparam iq_sel_t IQ_MEM  = 2'd2;
  localparam iq_sel_t IQ_NONE = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_id;
    logic [UOP_W-1:0] uop;
  } write_req_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
//------------------------------------------------------------------------------
// Module : dispatch_ctrl
// Brief  : Single-entry dispatch buffer issuing a whole group to the issue
//          queues all-or-nothing, with dispatch and stall counters.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dispatch_ctrl
  import issue_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int NQ          = NUM_IQ
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  write_req_t [FETCH_WIDTH-1:0]          in_group,
  input  iq_sel_t    [FETCH_WIDTH-1:0]          in_qsel,
  input  logic       [NQ-1:0]                   iq_full,
  output logic       [NQ-1:0]                   iq_wen,
  output write_req_t [NQ-1:0][FETCH_WIDTH-1:0]  iq_write,
  output logic       [31:0]                     stat_disp,
  output logic       [31:0]                     stat_stall
);

  function automatic logic [31:0] popcount(input logic [FETCH_WIDTH-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  disp_state_t                    r_state;
  disp_state_t                    w_state_nxt;
  write_req_t [FETCH_WIDTH-1:0]   r_buf_group;
  iq_sel_t    [FETCH_WIDTH-1:0]   r_buf_qsel;
  logic       [31:0]              r_stat_disp;
  logic       [31:0]              r_stat_stall;

  logic                           w_buf_valid;
  logic       [NQ-1:0]            w_need;
  logic       [FETCH_WIDTH-1:0]   w_slot_wr;
  logic                           w_fire;
  logic                           w_accept;

  assign w_buf_valid = (r_state == ST_HELD);

  // Queue writes come only from the buffer registers; qsel values beyond the
  // last queue match no queue, so those slots are silently dropped.
  always_comb begin
    w_need    = '0;
    w_slot_wr = '0;
    for (int q = 0; q < NQ; q++) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        iq_write[q][i]       = r_buf_group[i];
        iq_write[q][i].valid = w_buf_valid & r_buf_group[i].valid &
                               (r_buf_qsel[i] == iq_sel_t'(q));
        w_need[q]    = w_need[q] | iq_write[q][i].valid;
        w_slot_wr[i] = w_slot_wr[i] | iq_write[q][i].valid;
      end
    end
  end

  assign w_fire   = w_buf_valid & ~flush & ~(|(w_need & iq_full));
  assign iq_wen   = {NQ{w_fire}} & w_need;
  assign in_ready = ~flush & (~w_buf_valid | w_fire);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)         w_state_nxt = ST_EMPTY;
    else if (w_accept) w_state_nxt = ST_HELD;
    else if (w_fire)   w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_stat_disp  <= '0;
      r_stat_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire)
        r_stat_disp <= r_stat_disp + popcount(w_slot_wr);
      if (w_buf_valid & ~flush & ~w_fire)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  // Payload is qualified by r_state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_group <= in_group;
      r_buf_qsel  <= in_qsel;
    end
  end

  assign stat_disp  = r_stat_disp;
  assign stat_stall = r_stat_stall;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_dispatch_ctrl
// Brief  : Directed self-checking bench for dispatch_ctrl.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dispatch_ctrl;
  import issue_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  write_req_t [3:0]            in_group;
  iq_sel_t    [3:0]            in_qsel;
  logic       [2:0]            iq_full;
  logic       [2:0]            iq_wen;
  write_req_t [2:0][3:0]       iq_write;
  logic       [31:0]           stat_disp;
  logic       [31:0]           stat_stall;

  int total = 0;
  int bad   = 0;

  dispatch_ctrl #(.FETCH_WIDTH(4), .NQ(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_group  (in_group),
    .in_qsel   (in_qsel),
    .iq_full   (iq_full),
    .iq_wen    (iq_wen),
    .iq_write  (iq_write),
    .stat_disp (stat_disp),
    .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_q(input int q);
    int n = 0;
    for (int i = 0; i < 4; i++) if (iq_write[q][i].valid) n++;
    return n;
  endfunction

  // Slot i gets uop base+i, valid per vmask bit
  task automatic set_group(input logic [15:0] base, input logic [3:0] vmask,
                           input iq_sel_t s0, input iq_sel_t s1,
                           input iq_sel_t s2, input iq_sel_t s3);
    for (int i = 0; i < 4; i++) begin
      in_group[i].valid  = vmask[i];
      in_group[i].rob_id = 6'(base + 16'(i));
      in_group[i].uop    = base + 16'(i);
    end
    in_qsel[0] = s0; in_qsel[1] = s1; in_qsel[2] = s2; in_qsel[3] = s3;
  endtask

  task automatic do_reset();
    flush = 1'b0; in_valid = 1'b0; iq_full = 3'b000;
    set_group(16'h0, 4'h0, IQ_ALU, IQ_ALU, IQ_ALU, IQ_ALU);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (iq_wen !== 3'b000) begin bad++; $display("FAIL reset_iq_wen got=%b exp=000", iq_wen); end
    total++; if (stat_disp !== 32'd0 || stat_stall !== 32'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_disp, stat_stall); end
  endtask

  task automatic test_alu4();
    do_reset();
    set_group(16'h10, 4'hF, IQ_ALU, IQ_ALU, IQ_ALU, IQ_ALU);
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu4_ready got=%b exp=1", in_ready); end
    total++; if (iq_wen !== 3'b000) begin bad++; $display("FAIL alu4_latency got=%b exp=000", iq_wen); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (iq_wen !== 3'b001) begin bad++; $display("FAIL alu4_wen got=%b exp=001", iq_wen); end
    total++; if (cnt_q(0) != 4 || cnt_q(1) != 0 || cnt_q(2) != 0) begin
      bad++; $display("FAIL alu4_writes got=%0d/%0d/%0d exp=4/0/0", cnt_q(0), cnt_q(1), cnt_q(2)); end
    total++; if (iq_write[0][2].uop !== 16'h12) begin bad++; $display("FAIL alu4_payload got=%h exp=0012", iq_write[0][2].uop); end
    tick();
    total++; if (stat_disp !== 32'd4) begin bad++; $display("FAIL alu4_disp got=%0d exp=4", stat_disp); end
    total++; if (iq_wen !== 3'b000) begin bad++; $display("FAIL alu4_wen_after got=%b exp=000", iq_wen); end
  endtask

  task automatic test_stall();
    do_reset();
    iq_full = 3'b100;
    set_group(16'h20, 4'hF, IQ_ALU, IQ_BR, IQ_MEM, IQ_ALU);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (iq_wen !== 3'b000 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_blocked cyc=%0d wen=%b ready=%b exp=000/0", k, iq_wen, in_ready); end
      tick();
    end
    total++; if (stat_stall !== 32'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", stat_stall); end
    iq_full = 3'b000;
    #1;
    total++; if (iq_wen !== 3'b111 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release wen=%b ready=%b exp=111/1", iq_wen, in_ready); end
    tick();
    total++; if (iq_wen !== 3'b000 || stat_disp !== 32'd4 || stat_stall !== 32'd3) begin
      bad++; $display("FAIL stall_after wen=%b disp=%0d stall=%0d exp=000/4/3", iq_wen, stat_disp, stat_stall); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    set_group(16'h100, 4'hF, IQ_ALU, IQ_ALU, IQ_ALU, IQ_ALU);
    tick();
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) set_group(16'h100 + 16'(k * 16), 4'hF, IQ_ALU, IQ_ALU, IQ_ALU, IQ_ALU);
      else        in_valid = 1'b0;
      #1;
      total++; if (iq_wen !== 3'b001 || in_ready !== 1'b1 ||
                   iq_write[0][1].uop !== 16'h101 + 16'((k - 1) * 16)) begin
        bad++; $display("FAIL b2b cyc=%0d wen=%b ready=%b uop=%h exp=001/1/%h", k, iq_wen, in_ready,
                        iq_write[0][1].uop, 16'h101 + 16'((k - 1) * 16)); end
      tick();
    end
    total++; if (stat_disp !== 32'd40 || stat_stall !== 32'd0) begin
      bad++; $display("FAIL b2b_stats disp=%0d stall=%0d exp=40/0", stat_disp, stat_stall); end
  endtask

  task automatic test_flush();
    do_reset();
    iq_full = 3'b001;
    set_group(16'h30, 4'hF, IQ_ALU, IQ_ALU, IQ_ALU, IQ_ALU);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    set_group(16'h40, 4'hF, IQ_BR, IQ_BR, IQ_BR, IQ_BR);
    in_valid = 1'b1;
    flush    = 1'b1;
    iq_full  = 3'b000;
    #1;
    total++; if (iq_wen !== 3'b000 || in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_cycle wen=%b ready=%b exp=000/0", iq_wen, in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (iq_wen !== 3'b000 || in_ready !== 1'b1 || cnt_q(0) != 0 || cnt_q(1) != 0) begin
      bad++; $display("FAIL flush_cleared wen=%b ready=%b q0=%0d q1=%0d exp=000/1/0/0", iq_wen, in_ready, cnt_q(0), cnt_q(1)); end
    tick();
    tick();
    total++; if (stat_disp !== 32'd0 || stat_stall !== 32'd1) begin
      bad++; $display("FAIL flush_stats disp=%0d stall=%0d exp=0/1", stat_disp, stat_stall); end
  endtask

  task automatic test_drop_and_empty();
    do_reset();
    set_group(16'h50, 4'hF, IQ_NONE, IQ_BR, IQ_BR, IQ_BR);
    in_valid = 1'b1;
    tick();
    set_group(16'h60, 4'h0, IQ_ALU, IQ_BR, IQ_MEM, IQ_ALU);
    #1;
    total++; if (iq_wen !== 3'b010 || cnt_q(1) != 3 || cnt_q(0) != 0 || cnt_q(2) != 0) begin
      bad++; $display("FAIL drop_wen wen=%b q=%0d/%0d/%0d exp=010/0/3/0", iq_wen, cnt_q(0), cnt_q(1), cnt_q(2)); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (stat_disp !== 32'd3) begin bad++; $display("FAIL drop_disp got=%0d exp=3", stat_disp); end
    total++; if (iq_wen !== 3'b000 || in_ready !== 1'b1) begin
      bad++; $display("FAIL empty_group wen=%b ready=%b exp=000/1", iq_wen, in_ready); end
    tick();
    total++; if (stat_disp !== 32'd3 || stat_stall !== 32'd0) begin
      bad++; $display("FAIL empty_stats disp=%0d stall=%0d exp=3/0", stat_disp, stat_stall); end
  endtask

  task automatic test_reset_mid_held();
    do_reset();
    iq_full = 3'b010;
    set_group(16'h70, 4'hF, IQ_BR, IQ_BR, IQ_ALU, IQ_ALU);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || iq_wen !== 3'b000 || cnt_q(1) != 0) begin
      bad++; $display("FAIL async_reset ready=%b wen=%b q1=%0d exp=1/000/0", in_ready, iq_wen, cnt_q(1)); end
    tick();
    reset = 1'b0;
    iq_full = 3'b000;
    #1;
    total++; if (iq_wen !== 3'b000) begin bad++; $display("FAIL reset_discard wen=%b exp=000", iq_wen); end
    tick();
    total++; if (stat_disp !== 32'd0) begin bad++; $display("FAIL reset_discard_disp got=%0d exp=0", stat_disp); end
  endtask

  task automatic test_stall_wrap();
    do_reset();
    force dut.r_stat_stall = 32'hFFFF_FFFF;
    tick();
    release dut.r_stat_stall;
    #1;
    total++; if (stat_stall !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffffffff", stat_stall); end
    iq_full = 3'b001;
    set_group(16'h80, 4'hF, IQ_ALU, IQ_ALU, IQ_ALU, IQ_ALU);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (stat_stall !== 32'd0) begin bad++; $display("FAIL wrap_zero got=%h exp=00000000", stat_stall); end
    tick();
    total++; if (stat_stall !== 32'd1) begin bad++; $display("FAIL wrap_one got=%h exp=00000001", stat_stall); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; iq_full = 3'b000;
    in_group = '0; in_qsel = '0;
    #2;
    test_reset();
    test_alu4();
    test_stall();
    test_back_to_back();
    test_flush();
    test_drop_and_empty();
    test_reset_mid_held();
    test_stall_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
